// File: rtl/simd_loop_iter_ctrl_pkg.sv
// rtl/simd_loop_iter_ctrl_pkg.sv - shared defaults, FSM encoding and iter_done bit order
package simd_loop_iter_ctrl_pkg;

  localparam int LOOP_ID_W_DEF     = 5;
  localparam int LOOP_ITER_W_DEF   = 16;
  localparam int NUM_MAX_LOOPS_DEF = 1 << LOOP_ID_W_DEF;

  // iter_done[NUM_MAX_LOOPS] is the innermost tick, [i] is "loop i wrapped", [0] is nest done
  localparam int ITER_DONE_NEST_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } loop_state_e;

endpackage

// File: rtl/simd_loop_counter_cell.sv
// rtl/simd_loop_counter_cell.sv - one loop level: iteration counter plus its last-index register
module simd_loop_counter_cell
  import simd_loop_iter_ctrl_pkg::*;
#(
  parameter int LOOP_ITER_W = LOOP_ITER_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we_i,
  input  logic                   cfg_clr_i,
  input  logic [LOOP_ITER_W-1:0] cfg_data_i,
  input  logic                   clr_i,
  input  logic                   inc_i,
  output logic                   wrap_o
);

  logic [LOOP_ITER_W-1:0] cnt_q, cnt_d;
  logic [LOOP_ITER_W-1:0] last_q, last_d;

  // inc_i is the wrap of the next-inner level, so a wrap here only happens on a step
  assign wrap_o = inc_i & (cnt_q == last_q);

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + LOOP_ITER_W'(1);
    end
    if (cfg_clr_i) begin
      last_d = '0;
    end else if (cfg_we_i) begin
      last_d = cfg_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/simd_loop_iter_ctrl.sv
// rtl/simd_loop_iter_ctrl.sv - loop-nest iteration controller driving the stride walker's iter_done
module simd_loop_iter_ctrl
  import simd_loop_iter_ctrl_pkg::*;
#(
  parameter int LOOP_ID_W     = LOOP_ID_W_DEF,
  parameter int NUM_MAX_LOOPS = 1 << LOOP_ID_W,
  parameter int LOOP_ITER_W   = LOOP_ITER_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_loop_iter_v,
  input  logic [LOOP_ITER_W-1:0] cfg_loop_iter,
  input  logic                   block_done,
  input  logic                   start,
  input  logic                   stall,
  output logic [NUM_MAX_LOOPS:0] iter_done,
  output logic                   busy,
  output logic                   done
);

  loop_state_e          state_q, state_d;
  logic [LOOP_ID_W-1:0] wr_ptr_q, wr_ptr_d;
  logic                 tick;
  logic                 cfg_we;
  logic                 cnt_clr;

  assign tick    = (state_q == ST_RUN) & ~stall;
  assign cfg_we  = (state_q == ST_IDLE) & cfg_loop_iter_v & ~block_done;
  assign cnt_clr = (state_q == ST_IDLE) & start;
  assign iter_done[NUM_MAX_LOOPS] = tick;

  // Each level gets its own wrap net so the ripple chain is not a self-dependent vector
  for (genvar g = 0; g < NUM_MAX_LOOPS; g++) begin : g_lvl
    logic inc;
    logic wrap;
    if (g == NUM_MAX_LOOPS - 1) begin : g_inner
      assign inc = tick;
    end else begin : g_outer
      assign inc = g_lvl[g+1].wrap;
    end

    simd_loop_counter_cell #(
      .LOOP_ITER_W (LOOP_ITER_W)
    ) u_cell (
      .clk        (clk),
      .reset      (reset),
      .cfg_we_i   (cfg_we && (wr_ptr_q == LOOP_ID_W'(g))),
      .cfg_clr_i  (block_done),
      .cfg_data_i (cfg_loop_iter),
      .clr_i      (cnt_clr),
      .inc_i      (inc),
      .wrap_o     (wrap)
    );

    assign iter_done[g] = wrap;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (block_done) begin
      wr_ptr_d = '0;
    end else if (cfg_we && (wr_ptr_q != LOOP_ID_W'(NUM_MAX_LOOPS - 1))) begin
      wr_ptr_d = wr_ptr_q + LOOP_ID_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != ST_IDLE);
    done    = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ALIGN;
      ST_ALIGN: state_d = ST_RUN;
      ST_RUN:   if (iter_done[ITER_DONE_NEST_BIT]) state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule
